// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: command encodings, status bit indices and requester count shared by the ALU arbiter slice
package alu_arbiter_pkg;
    localparam logic [3:0] EXE_MOV = 4'b0001;
    localparam logic [3:0] EXE_MVN = 4'b1001;
    localparam logic [3:0] EXE_ADD = 4'b0010;
    localparam logic [3:0] EXE_ADC = 4'b0011;
    localparam logic [3:0] EXE_SUB = 4'b0100;
    localparam logic [3:0] EXE_SBC = 4'b0101;
    localparam logic [3:0] EXE_AND = 4'b0110;
    localparam logic [3:0] EXE_ORR = 4'b0111;
    localparam logic [3:0] EXE_EOR = 4'b1000;
    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;
    localparam int NREQ = 2;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: 32-bit ALU with {N,Z,C,V} flags; subtraction is a + ~b + carry so C means no-borrow
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [3:0]  cmd,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic        cin,
    output logic [31:0] res,
    output logic [3:0]  status
);
    logic        arith;
    logic        ci;
    logic [31:0] b;
    logic [32:0] sum;
    always_comb begin
        arith  = cmd inside {EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC};
        b      = (cmd == EXE_SUB || cmd == EXE_SBC) ? ~val2 : val2;
        ci     = cmd == EXE_SUB ? 1'b1 : (cmd == EXE_ADC || cmd == EXE_SBC) ? cin : 1'b0;
        sum    = {1'b0, val1} + {1'b0, b} + {32'd0, ci};
        res    = arith ? sum[31:0] :
                 cmd == EXE_MOV ? val2 :
                 cmd == EXE_MVN ? ~val2 :
                 cmd == EXE_AND ? val1 & val2 :
                 cmd == EXE_ORR ? val1 | val2 :
                 cmd == EXE_EOR ? val1 ^ val2 : 32'd0;
        status = {res[31], res == 32'd0, arith & sum[32],
                  arith & (val1[31] == b[31]) & (res[31] != val1[31])};
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with registered responses and status register
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req_valid,
    output logic        r0_req_ready,
    input  logic [3:0]  r0_exe_cmd,
    input  logic [31:0] r0_val1,
    input  logic [31:0] r0_val2,
    input  logic        r0_s,
    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [31:0] r0_rsp_res,
    output logic [3:0]  r0_rsp_status,
    input  logic        r1_req_valid,
    output logic        r1_req_ready,
    input  logic [3:0]  r1_exe_cmd,
    input  logic [31:0] r1_val1,
    input  logic [31:0] r1_val2,
    input  logic        r1_s,
    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [31:0] r1_rsp_res,
    output logic [3:0]  r1_rsp_status,
    output logic [3:0]  sr
);
    logic        last;
    logic        e0, e1, g0, g1;
    logic [3:0]  cmd, alu_status;
    logic [31:0] a, b, alu_res;
    assign e0 = r0_req_valid & (~r0_rsp_valid | r0_rsp_ready);
    assign e1 = r1_req_valid & (~r1_rsp_valid | r1_rsp_ready);
    // last == 1 means requester 1 was served most recently, so a tie goes to 0
    assign g0 = ~rst & e0 & (~e1 | last);
    assign g1 = ~rst & e1 & (~e0 | ~last);
    assign r0_req_ready = g0;
    assign r1_req_ready = g1;
    assign cmd = g1 ? r1_exe_cmd : r0_exe_cmd;
    assign a   = g1 ? r1_val1 : r0_val1;
    assign b   = g1 ? r1_val2 : r0_val2;
    alu_arbiter_alu u_alu (
        .cmd    (cmd),
        .val1   (a),
        .val2   (b),
        .cin    (sr[SR_C]),
        .res    (alu_res),
        .status (alu_status)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            last          <= 1'b1;
            sr            <= 4'd0;
            r0_rsp_valid  <= 1'b0;
            r0_rsp_res    <= 32'd0;
            r0_rsp_status <= 4'd0;
            r1_rsp_valid  <= 1'b0;
            r1_rsp_res    <= 32'd0;
            r1_rsp_status <= 4'd0;
        end else begin
            if (g0 | g1) last <= g1;
            if ((g0 & r0_s) | (g1 & r1_s)) sr <= alu_status;
            if (g0) begin
                r0_rsp_valid  <= 1'b1;
                r0_rsp_res    <= alu_res;
                r0_rsp_status <= alu_status;
            end else if (r0_rsp_ready) begin
                r0_rsp_valid  <= 1'b0;
            end
            if (g1) begin
                r1_rsp_valid  <= 1'b1;
                r1_rsp_res    <= alu_res;
                r1_rsp_status <= alu_status;
            end else if (r1_rsp_ready) begin
                r1_rsp_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table vectors, directed corner sequences and a randomized run against a behavioural model
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [3:0]  cmd [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic        s [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_res [2];
    logic [3:0]  rsp_status [2];
    logic [3:0]  sr;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_req_valid(req_valid[0]), .r0_req_ready(req_ready[0]), .r0_exe_cmd(cmd[0]),
        .r0_val1(a[0]), .r0_val2(b[0]), .r0_s(s[0]), .r0_rsp_valid(rsp_valid[0]),
        .r0_rsp_ready(rsp_ready[0]), .r0_rsp_res(rsp_res[0]), .r0_rsp_status(rsp_status[0]),
        .r1_req_valid(req_valid[1]), .r1_req_ready(req_ready[1]), .r1_exe_cmd(cmd[1]),
        .r1_val1(a[1]), .r1_val2(b[1]), .r1_s(s[1]), .r1_rsp_valid(rsp_valid[1]),
        .r1_rsp_ready(rsp_ready[1]), .r1_rsp_res(rsp_res[1]), .r1_rsp_status(rsp_status[1]),
        .sr(sr)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] res;
        logic [3:0]  st;
        logic [3:0]  sr;
    } vec_t;
    vec_t tv [19];

    // model state
    logic        m_valid [2];
    logic [31:0] m_res [2];
    logic [3:0]  m_stat [2];
    logic [3:0]  m_sr;
    int          m_last;
    logic        m_grant [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic done on 64-bit integers; carry and overflow come from range tests
    function automatic void alu_ref(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                                    input logic ci, output logic [31:0] r, output logic [3:0] st);
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint cn = ci ? 64'sd1 : 64'sd0;
        longint bo = ci ? 64'sd0 : 64'sd1;
        longint full = 0;
        bit cf = 0;
        bit vf;
        case (c)
            EXE_MOV: r = y;
            EXE_MVN: r = ~y;
            EXE_ADD: begin r = x + y; cf = ux + uy > 64'sd4294967295; full = sx + sy; end
            EXE_ADC: begin r = x + y + {31'd0, ci}; cf = ux + uy + cn > 64'sd4294967295; full = sx + sy + cn; end
            EXE_SUB: begin r = x - y; cf = ux >= uy; full = sx - sy; end
            EXE_SBC: begin r = x - y - {31'd0, ~ci}; cf = ux >= uy + bo; full = sx - sy - bo; end
            EXE_AND: r = x & y;
            EXE_ORR: r = x | y;
            EXE_EOR: r = x ^ y;
            default: r = 32'd0;
        endcase
        vf = full > 64'sd2147483647 || full < -64'sd2147483648;
        st = {r[31], r == 32'd0, cf, vf};
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_inputs();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = 1'b0; cmd[i] = 4'd0; a[i] = 32'd0; b[i] = 32'd0;
            s[i] = 1'b0; rsp_ready[i] = 1'b1;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input logic [3:0] c, input logic [31:0] x,
                          input logic [31:0] y, input logic sf);
        req_valid[i] = 1'b1; cmd[i] = c; a[i] = x; b[i] = y; s[i] = sf;
    endtask

    initial begin
        tv[0]  = '{EXE_ADD, 32'h7FFFFFFF, 32'd1,        1'b1, 32'h80000000, 4'b1001, 4'b1001};
        tv[1]  = '{EXE_ADD, 32'hFFFFFFFF, 32'd1,        1'b1, 32'h00000000, 4'b0110, 4'b0110};
        tv[2]  = '{EXE_ADC, 32'd0,        32'd0,        1'b1, 32'h00000001, 4'b0000, 4'b0000};
        tv[3]  = '{EXE_SUB, 32'd5,        32'd3,        1'b1, 32'h00000002, 4'b0010, 4'b0010};
        tv[4]  = '{EXE_SBC, 32'd5,        32'd3,        1'b1, 32'h00000002, 4'b0010, 4'b0010};
        tv[5]  = '{EXE_SUB, 32'd3,        32'd5,        1'b1, 32'hFFFFFFFE, 4'b1000, 4'b1000};
        tv[6]  = '{EXE_SBC, 32'd5,        32'd3,        1'b1, 32'h00000001, 4'b0010, 4'b0010};
        tv[7]  = '{EXE_SUB, 32'h80000000, 32'd1,        1'b1, 32'h7FFFFFFF, 4'b0011, 4'b0011};
        tv[8]  = '{EXE_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 32'hF000F000, 4'b1000, 4'b1000};
        tv[9]  = '{EXE_ORR, 32'h0F0F0000, 32'h000000F0, 1'b1, 32'h0F0F00F0, 4'b0000, 4'b0000};
        tv[10] = '{EXE_EOR, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 4'b0100, 4'b0100};
        tv[11] = '{EXE_MOV, 32'h12345678, 32'h80000001, 1'b1, 32'h80000001, 4'b1000, 4'b1000};
        tv[12] = '{EXE_MVN, 32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 4'b1000, 4'b1000};
        tv[13] = '{4'b1111, 32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h00000000, 4'b0100, 4'b0100};
        tv[14] = '{EXE_ADD, 32'd1,        32'd1,        1'b0, 32'h00000002, 4'b0000, 4'b0100};
        tv[15] = '{EXE_ADC, 32'hFFFFFFFF, 32'd1,        1'b1, 32'h00000000, 4'b0110, 4'b0110};
        tv[16] = '{4'b0000, 32'd7,        32'd9,        1'b1, 32'h00000000, 4'b0100, 4'b0100};
        tv[17] = '{EXE_SBC, 32'd0,        32'd0,        1'b1, 32'hFFFFFFFF, 4'b1000, 4'b1000};
        tv[18] = '{EXE_ADD, 32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 4'b0111, 4'b0111};

        // reset state, with requests presented during reset
        idle_inputs();
        set_op(0, EXE_ADD, 32'd1, 32'd1, 1'b1);
        set_op(1, EXE_ADD, 32'd2, 32'd2, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_ready0", req_ready[0], 1'b0);
        chk("rst_ready1", req_ready[1], 1'b0);
        @(posedge clk); #1;
        chk("rst_valid0", rsp_valid[0], 1'b0);
        chk("rst_valid1", rsp_valid[1], 1'b0);
        chk("rst_res0", rsp_res[0], 32'd0);
        chk("rst_stat1", rsp_status[1], 4'd0);
        chk("rst_sr", sr, 4'd0);
        rst = 1'b0;
        idle_inputs();

        // table vectors through requester 0
        for (int i = 0; i < 19; i++) begin
            set_op(0, tv[i].cmd, tv[i].a, tv[i].b, tv[i].s);
            #1;
            chk("tv_ready", req_ready[0], 1'b1);
            @(posedge clk); #1;
            req_valid[0] = 1'b0;
            chk("tv_valid", rsp_valid[0], 1'b1);
            chk("tv_res", rsp_res[0], tv[i].res);
            chk("tv_status", rsp_status[0], tv[i].st);
            chk("tv_sr", sr, tv[i].sr);
        end

        // tie alternation
        do_reset();
        set_op(0, EXE_ADD, 32'd100, 32'd1, 1'b0);
        set_op(1, EXE_ADD, 32'd200, 32'd2, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_ready0", req_ready[0], (k % 2) == 0);
            chk("tie_ready1", req_ready[1], (k % 2) == 1);
            @(posedge clk); #1;
            chk("tie_valid0", rsp_valid[0], (k % 2) == 0);
            chk("tie_valid1", rsp_valid[1], (k % 2) == 1);
            if (k % 2 == 0) chk("tie_res0", rsp_res[0], 32'd101);
            else            chk("tie_res1", rsp_res[1], 32'd202);
        end

        // carry chain through sr, then the same with S=0 on the first op
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            set_op(0, EXE_ADD, 32'hFFFFFFFF, 32'd1, pass == 0);
            @(posedge clk); #1;
            chk("cc_res1", rsp_res[0], 32'd0);
            chk("cc_stat1", rsp_status[0], 4'b0110);
            set_op(0, EXE_ADC, 32'd0, 32'd0, 1'b0);
            @(posedge clk); #1;
            req_valid[0] = 1'b0;
            chk("cc_res2", rsp_res[0], pass == 0 ? 32'd1 : 32'd0);
        end

        // backpressure on requester 1
        do_reset();
        rsp_ready[1] = 1'b0;
        rsp_ready[0] = 1'b0;
        set_op(1, EXE_ADD, 32'd1, 32'd1, 1'b0);
        #1 chk("bp_first1", req_ready[1], 1'b1);
        @(posedge clk); #1;
        set_op(1, EXE_ADD, 32'h80000000, 32'h80000000, 1'b1);
        set_op(0, EXE_ADD, 32'd5, 32'd5, 1'b0);
        #1;
        chk("bp_block1", req_ready[1], 1'b0);
        chk("bp_serve0", req_ready[0], 1'b1);
        @(posedge clk); #1;
        chk("bp_res0", rsp_res[0], 32'd10);
        chk("bp_hold1", rsp_res[1], 32'd2);
        req_valid[0] = 1'b0;
        rsp_ready[1] = 1'b1;
        #1 chk("bp_release1", req_ready[1], 1'b1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        chk("bp_valid1", rsp_valid[1], 1'b1);
        chk("bp_res1", rsp_res[1], 32'd0);
        chk("bp_sr", sr, 4'b0111);
        chk("bp_valid0", rsp_valid[0], 1'b1);

        // reset with both responses pending and both requests valid
        rsp_ready[0] = 1'b0; rsp_ready[1] = 1'b0;
        set_op(0, EXE_ADD, 32'd3, 32'd4, 1'b1);
        set_op(1, EXE_ADD, 32'd5, 32'd6, 1'b1);
        rst = 1'b1;
        #1;
        chk("mr_ready0", req_ready[0], 1'b0);
        chk("mr_ready1", req_ready[1], 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_valid0", rsp_valid[0], 1'b0);
        chk("mr_valid1", rsp_valid[1], 1'b0);
        chk("mr_sr", sr, 4'd0);
        rsp_ready[0] = 1'b1; rsp_ready[1] = 1'b1;
        #1;
        chk("mr_tie0", req_ready[0], 1'b1);
        chk("mr_tie1", req_ready[1], 1'b0);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            m_valid[i] = 1'b0; m_res[i] = 32'd0; m_stat[i] = 4'd0; m_grant[i] = 1'b0;
        end
        m_sr = 4'd0;
        m_last = 1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic el [2];
            logic [31:0] r;
            logic [3:0] st;
            int gi;
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && !m_grant[i])) begin
                    req_valid[i] = $urandom_range(0, 9) < 7;
                    cmd[i] = 4'($urandom_range(0, 15));
                    a[i] = rnd_op();
                    b[i] = rnd_op();
                    s[i] = 1'($urandom_range(0, 1));
                end
                rsp_ready[i] = $urandom_range(0, 9) < 7;
            end
            #1;
            for (int i = 0; i < NREQ; i++) el[i] = req_valid[i] && (!m_valid[i] || rsp_ready[i]);
            gi = (el[0] && el[1]) ? 1 - m_last : (el[1] ? 1 : (el[0] ? 0 : -1));
            for (int i = 0; i < NREQ; i++) begin
                m_grant[i] = gi == i;
                chk("rnd_ready", req_ready[i], m_grant[i]);
                chk("rnd_valid", rsp_valid[i], m_valid[i]);
                if (m_valid[i]) begin
                    chk("rnd_res", rsp_res[i], m_res[i]);
                    chk("rnd_status", rsp_status[i], m_stat[i]);
                end
            end
            chk("rnd_sr", sr, m_sr);
            for (int i = 0; i < NREQ; i++) begin
                if (m_grant[i]) begin
                    alu_ref(cmd[i], a[i], b[i], m_sr[SR_C], r, st);
                    m_res[i] = r; m_stat[i] = st; m_valid[i] = 1'b1;
                    if (s[i]) m_sr = st;
                    m_last = i;
                end else if (rsp_ready[i]) begin
                    m_valid[i] = 1'b0;
                end
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
